bin_conv3x3_stream: RTL and testbench

- Streaming 3x3 binary convolution stage. Sits directly upstream of the 2x2 OR max-pooling stage and feeds it.
- Accepts a 1-bit raster-order feature map, W x H pixels, one pixel per enabled cycle.
- Emits one valid-padding result bit per interior window: (W-2) x (H-2) bits in raster order.
- Per window, the result is popcount(XNOR(window, weights)) >= threshold. Default 32x32 in gives 30x30 out, matching the pooler line length of 30.

---
 rtl/bin_conv3x3_stream.sv | 121 ++++++++++++
 tb/tb_bin_conv3x3_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_conv3x3_stream.sv
// Streaming 3x3 binary (XNOR-popcount) convolution over a raster-order 1-bit image.
// Emits one thresholded bit per interior window, registered, one cycle after the accepting edge.
module bin_conv3x3_stream #(
  parameter int W  = 32,
  parameter int H  = 32,
  parameter int CB = 5,
  parameter int RB = 5
) (
  input  logic       iCLK,
  input  logic       iRSTn,
  input  logic       iEN,
  input  logic       iCLR,
  input  logic       iDATA,
  input  logic [8:0] iWEIGHT,
  input  logic [3:0] iTHR,
  output logic       oDATA,
  output logic       oVALID,
  output logic       oDONE
);

  logic [CB-1:0] col_q, col_d;
  logic [RB-1:0] row_q, row_d;
  logic [W-1:0]  lb1_q;  // row r-1, indexed by column
  logic [W-1:0]  lb2_q;  // row r-2, indexed by column
  logic [8:0]    win_q, win_d;
  logic          data_q, data_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          accept;
  logic          col_last, row_last;
  logic          tap1, tap2;
  logic [2:0]    new_col;
  logic [8:0]    match;
  logic [3:0]    pc;
  logic          result;
  logic          out_fire;

  assign accept   = iEN & ~iCLR;
  assign col_last = (col_q == CB'(W - 1));
  assign row_last = (row_q == RB'(H - 1));
  assign tap1     = lb1_q[col_q];
  assign tap2     = lb2_q[col_q];
  // Right-hand window column, top (oldest line) at index 0.
  assign new_col  = {iDATA, tap1, tap2};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win_row
      assign win_d[3*gi + 0] = win_q[3*gi + 1];
      assign win_d[3*gi + 1] = win_q[3*gi + 2];
      assign win_d[3*gi + 2] = new_col[gi];
    end
  endgenerate

  assign match = ~(win_d ^ iWEIGHT);

  always_comb begin
    pc = '0;
    for (int k = 0; k < 9; k++) begin
      pc = pc + 4'(match[k]);
    end
  end

  assign result   = (pc >= iTHR);
  assign out_fire = accept && (row_q >= RB'(2)) && (col_q >= CB'(2));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = out_fire;
    data_d  = out_fire & result;
    done_d  = out_fire & row_last & col_last;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RB'(1);
      end else begin
        col_d = col_q + CB'(1);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      col_q   <= '0;
      row_q   <= '0;
      lb1_q   <= '0;
      lb2_q   <= '0;
      win_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (iCLR) begin
      col_q   <= '0;
      row_q   <= '0;
      lb1_q   <= '0;
      lb2_q   <= '0;
      win_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (accept) begin
        win_q        <= win_d;
        lb1_q[col_q] <= iDATA;
        lb2_q[col_q] <= tap1;
      end
    end
  end

  assign oDATA  = data_q;
  assign oVALID = valid_q;
  assign oDONE  = done_q;

endmodule

// File: tb/tb_bin_conv3x3_stream.sv
// Directed bench for bin_conv3x3_stream: fixed and random 32x32 frames checked
// against a direct 2D window reference, plus clear and mid-frame reset behaviour.
module tb_bin_conv3x3_stream;

  typedef bit frame_t [1024];

  logic       iCLK;
  logic       iRSTn;
  logic       iEN;
  logic       iCLR;
  logic       iDATA;
  logic [8:0] iWEIGHT;
  logic [3:0] iTHR;
  logic       oDATA;
  logic       oVALID;
  logic       oDONE;

  bin_conv3x3_stream #(.W(32), .H(32), .CB(5), .RB(5)) dut (
    .iCLK    (iCLK),
    .iRSTn   (iRSTn),
    .iEN     (iEN),
    .iCLR    (iCLR),
    .iDATA   (iDATA),
    .iWEIGHT (iWEIGHT),
    .iTHR    (iTHR),
    .oDATA   (oDATA),
    .oVALID  (oVALID),
    .oDONE   (oDONE)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int n_checks = 0;
  int n_errors = 0;
  int idle_bad = 0;
  int acc_cnt  = 0;
  bit armed    = 1'b0;
  bit out_log  [$];
  bit done_log [$];
  int acc_log  [$];

  always @(posedge iCLK) begin
    if (iRSTn === 1'b1 && iEN === 1'b1 && iCLR !== 1'b1) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge iCLK) begin
    if (oVALID === 1'b1) begin
      out_log.push_back(oDATA);
      done_log.push_back(oDONE);
      acc_log.push_back(acc_cnt);
    end else if (armed && (oDATA !== 1'b0 || oDONE !== 1'b0)) begin
      idle_bad = idle_bad + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_bit(input frame_t f, input int idx,
                                   input logic [8:0] w, input logic [3:0] thr);
    int r = idx / 30;
    int c = idx % 30;
    int pc = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        if (f[(r + dr) * 32 + c + dc] == w[3 * dr + dc]) pc++;
    return (pc >= int'(thr)) ? 1 : 0;
  endfunction

  task automatic send_frame(input frame_t f, input int npix, input bit gaps);
    for (int p = 0; p < npix; p++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          iEN = 1'b0;
          @(posedge iCLK); #1;
        end
      end
      iDATA = f[p];
      iEN   = 1'b1;
      @(posedge iCLK); #1;
    end
    iEN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iCLK); #1;
    end
  endtask

  task automatic check_frame(input string tag, input frame_t f, input int base, input int n,
                             input int ab, input logic [8:0] w, input logic [3:0] thr,
                             input int exp_n, input bit exp_done, output int ones);
    int mism = 0;
    int dones = 0;
    int done_at = -1;
    int e;
    ones = 0;
    chk({tag, "_count"}, n, exp_n);
    for (int i = 0; i < n; i++) begin
      e = (i < 900) ? model_bit(f, i, w, thr) : 0;
      if (int'(out_log[base + i]) != e) mism++;
      ones += int'(out_log[base + i]);
      if (done_log[base + i]) begin
        dones++;
        done_at = i;
      end
    end
    chk({tag, "_mismatches"}, mism, 0);
    chk({tag, "_dones"}, dones, exp_done ? 1 : 0);
    if (exp_done) chk({tag, "_done_index"}, done_at, 899);
    if (n > 0) chk({tag, "_first_latency"}, acc_log[base] - ab, 67);
  endtask

  task automatic run_frame(input string tag, input frame_t f, input bit gaps,
                           input logic [8:0] w, input logic [3:0] thr, output int ones,
                           output int base);
    int ab;
    iWEIGHT = w;
    iTHR    = thr;
    base    = out_log.size();
    ab      = acc_cnt;
    send_frame(f, 1024, gaps);
    idle(3);
    check_frame(tag, f, base, out_log.size() - base, ab, w, thr, 900, 1'b1, ones);
  endtask

  frame_t f_ones, f_zero, f_single, f_a, f_b, f_c, f_d;
  int ones, base, base_a, ab_a, ab_b, ab_c;
  logic [8:0] w_rand;

  initial begin
    for (int p = 0; p < 1024; p++) begin
      f_ones[p]   = 1'b1;
      f_zero[p]   = 1'b0;
      f_single[p] = 1'b0;
      f_a[p]      = 1'($urandom);
      f_b[p]      = 1'($urandom);
      f_c[p]      = 1'($urandom);
      f_d[p]      = 1'($urandom);
    end
    f_single[5 * 32 + 7] = 1'b1;
    w_rand = 9'($urandom);

    iRSTn = 1'b1; iEN = 1'b0; iCLR = 1'b0; iDATA = 1'b0;
    iWEIGHT = 9'h1FF; iTHR = 4'd9;
    #2 iRSTn = 1'b0;
    #1;
    chk("reset_oVALID", int'(oVALID), 0);
    chk("reset_oDATA", int'(oDATA), 0);
    chk("reset_oDONE", int'(oDONE), 0);
    @(negedge iCLK);
    iRSTn = 1'b1;
    armed = 1'b1;
    @(posedge iCLK); #1;

    run_frame("ones", f_ones, 1'b0, 9'h1FF, 4'd9, ones, base);
    chk("ones_all_one", ones, 900);

    run_frame("zeros_w1ff", f_zero, 1'b0, 9'h1FF, 4'd1, ones, base);
    chk("zeros_w1ff_all_zero", ones, 0);
    run_frame("zeros_w000", f_zero, 1'b0, 9'h000, 4'd1, ones, base);
    chk("zeros_w000_all_one", ones, 900);

    run_frame("single", f_single, 1'b0, 9'h010, 4'd9, ones, base);
    chk("single_one_count", ones, 1);
    chk("single_at_126", int'(out_log[base + 126]), 1);

    // Two random frames back to back with random idle gaps.
    iWEIGHT = w_rand; iTHR = 4'd5;
    base_a = out_log.size();
    ab_a = acc_cnt;
    send_frame(f_a, 1024, 1'b1);
    ab_b = acc_cnt;
    send_frame(f_b, 1024, 1'b1);
    idle(3);
    chk("b2b_total", out_log.size() - base_a, 1800);
    check_frame("rand_a", f_a, base_a, 900, ab_a, w_rand, 4'd5, 900, 1'b1, ones);
    check_frame("rand_b", f_b, base_a + 900, out_log.size() - base_a - 900, ab_b,
                w_rand, 4'd5, 900, 1'b1, ones);

    // Clear lands on pixel 400 together with iEN.
    iWEIGHT = w_rand; iTHR = 4'd4;
    base = out_log.size();
    ab_c = acc_cnt;
    send_frame(f_c, 400, 1'b0);
    iCLR = 1'b1; iEN = 1'b1; iDATA = f_c[400];
    @(posedge iCLK); #1;
    iCLR = 1'b0; iEN = 1'b0;
    chk("clr_no_valid", int'(oVALID), 0);
    idle(2);
    check_frame("clr_partial", f_c, base, out_log.size() - base, ab_c, w_rand, 4'd4,
                314, 1'b0, ones);
    run_frame("after_clr", f_c, 1'b0, w_rand, 4'd4, ones, base);

    run_frame("thr0", f_d, 1'b1, w_rand, 4'd0, ones, base);
    chk("thr0_all_one", ones, 900);
    run_frame("thr10", f_d, 1'b0, w_rand, 4'd10, ones, base);
    chk("thr10_all_zero", ones, 0);

    // Pixel 499 is (15,19), an output pixel; with iTHR=0 its result is 1.
    iWEIGHT = w_rand; iTHR = 4'd0;
    send_frame(f_d, 500, 1'b0);
    chk("pre_rst_oVALID", int'(oVALID), 1);
    chk("pre_rst_oDATA", int'(oDATA), 1);
    #2 iRSTn = 1'b0;
    #1;
    chk("midrst_oVALID", int'(oVALID), 0);
    chk("midrst_oDATA", int'(oDATA), 0);
    chk("midrst_oDONE", int'(oDONE), 0);
    @(negedge iCLK);
    iRSTn = 1'b1;
    @(posedge iCLK); #1;
    run_frame("after_rst", f_d, 1'b0, w_rand, 4'd6, ones, base);

    chk("idle_outputs_clean", idle_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
